exe_issue_scheduler: RTL and testbench

//  Sequences decoded uops into the 2-stage execution unit. Buffers uops from decode, reads operands,

---
 rtl/exe_issue_scheduler_if.sv | 28 ++
 rtl/exe_issue_scheduler.sv | 167 ++++++++++++++++
 tb/tb_exe_issue_scheduler.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exe_issue_scheduler_if.sv
// exe_issue_scheduler_if: decode->scheduler uop handshake (valid/ready + uop fields).
// master = decoder side, slave = scheduler side.
interface exe_issue_scheduler_if #(
  parameter int REG_AW = 5
);
  logic              dec_valid;
  logic              dec_ready;
  logic [6:0]        dec_instr_type;
  logic [2:0]        dec_funct3;
  logic [6:0]        dec_funct7;
  logic [20:0]       dec_imm;
  logic [REG_AW-1:0] dec_rs1;
  logic [REG_AW-1:0] dec_rs2;
  logic [REG_AW-1:0] dec_rd;
  logic              dec_rd_wr;

  modport master (
    output dec_valid, dec_instr_type, dec_funct3, dec_funct7,
    output dec_imm, dec_rs1, dec_rs2, dec_rd, dec_rd_wr,
    input  dec_ready
  );

  modport slave (
    input  dec_valid, dec_instr_type, dec_funct3, dec_funct7,
    input  dec_imm, dec_rs1, dec_rs2, dec_rd, dec_rd_wr,
    output dec_ready
  );
endinterface

// File: rtl/exe_issue_scheduler.sv
// exe_issue_scheduler: uop FIFO, RF operand read, RAW scoreboard, result writeback.
// Ports: clk/reset, dec (uop handshake), system_stall, rf read/write, exe issue/result,
// sched_err, stall_cnt. Option: EXE_SCHED_BYPASS_EN (forward returning result).
module exe_issue_scheduler #(
  parameter int DATA_WIDTH  = 32,
  parameter int REG_AW      = 5,
  parameter int DEPTH       = 2,
  parameter int EXE_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  exe_issue_scheduler_if.slave  dec,
  input  logic                  system_stall,
  output logic [REG_AW-1:0]     rf_rs1_addr,
  output logic [REG_AW-1:0]     rf_rs2_addr,
  input  logic [DATA_WIDTH-1:0] rf_rs1_data,
  input  logic [DATA_WIDTH-1:0] rf_rs2_data,
  output logic                  exe_issue,
  output logic [6:0]            exe_instr_type,
  output logic [2:0]            exe_funct3,
  output logic [6:0]            exe_funct7,
  output logic [20:0]           exe_imm,
  output logic [DATA_WIDTH-1:0] exe_src1,
  output logic [DATA_WIDTH-1:0] exe_src2,
  input  logic [DATA_WIDTH-1:0] exe_result,
  input  logic                  exe_result_valid,
  output logic                  rf_wr_en,
  output logic [REG_AW-1:0]     rf_wr_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  sched_err,
  output logic [15:0]           stall_cnt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [6:0]        itype;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [20:0]       imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              rd_wr;
  } uop_t;

  uop_t              mem [DEPTH];
  uop_t              in_uop;
  uop_t              head;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic              empty;
  logic              push;
  logic              pop;

  logic [EXE_LATENCY:1] sb_v;
  logic [REG_AW-1:0]    sb_rd [EXE_LATENCY:1];

  logic haz1, haz2, byp1, byp2, hazard;

  assign in_uop = '{itype: dec.dec_instr_type, f3: dec.dec_funct3,
                    f7: dec.dec_funct7, imm: dec.dec_imm,
                    rs1: dec.dec_rs1, rs2: dec.dec_rs2,
                    rd: dec.dec_rd, rd_wr: dec.dec_rd_wr};

  assign empty         = (count == '0);
  assign dec.dec_ready = (count < (PW+1)'(DEPTH));
  assign push          = dec.dec_valid & dec.dec_ready;
  assign pop           = exe_issue;
  assign head          = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_uop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // SB[k] holds the uop issued k cycles ago; SB[EXE_LATENCY] returns now.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_v <= '0;
    end else begin
      sb_v[1]  <= exe_issue & head.rd_wr & (head.rd != '0);
      sb_rd[1] <= head.rd;
      for (int k = 2; k <= EXE_LATENCY; k++) begin
        sb_v[k]  <= sb_v[k-1];
        sb_rd[k] <= sb_rd[k-1];
      end
    end
  end

  always_comb begin
    haz1 = 1'b0;
    haz2 = 1'b0;
    byp1 = 1'b0;
    byp2 = 1'b0;
    for (int k = 1; k <= EXE_LATENCY; k++) begin
      if (sb_v[k]) begin
        if (k < EXE_LATENCY) begin
          if (head.rs1 != '0 && sb_rd[k] == head.rs1) haz1 = 1'b1;
          if (head.rs2 != '0 && sb_rd[k] == head.rs2) haz2 = 1'b1;
        end else begin
`ifdef EXE_SCHED_BYPASS_EN
          // returning result forwarded; without a result the RF value is used
          if (head.rs1 != '0 && sb_rd[k] == head.rs1) byp1 = exe_result_valid;
          if (head.rs2 != '0 && sb_rd[k] == head.rs2) byp2 = exe_result_valid;
`else
          // wait one more cycle so the RF holds the written value
          if (head.rs1 != '0 && sb_rd[k] == head.rs1) haz1 = 1'b1;
          if (head.rs2 != '0 && sb_rd[k] == head.rs2) haz2 = 1'b1;
`endif
        end
      end
    end
  end

  assign hazard      = haz1 | haz2;
  assign exe_issue   = !empty & !system_stall & !hazard;
  assign rf_rs1_addr = head.rs1;
  assign rf_rs2_addr = head.rs2;

  always_comb begin
    exe_instr_type = '0;
    exe_funct3     = '0;
    exe_funct7     = '0;
    exe_imm        = '0;
    exe_src1       = '0;
    exe_src2       = '0;
    if (exe_issue) begin
      exe_instr_type = head.itype;
      exe_funct3     = head.f3;
      exe_funct7     = head.f7;
      exe_imm        = head.imm;
      if (head.rs1 != '0) exe_src1 = byp1 ? exe_result : rf_rs1_data;
      if (head.rs2 != '0) exe_src2 = byp2 ? exe_result : rf_rs2_data;
    end
  end

  assign rf_wr_en   = exe_result_valid & sb_v[EXE_LATENCY];
  assign rf_wr_addr = sb_rd[EXE_LATENCY];
  assign rf_wr_data = exe_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      sched_err <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (exe_result_valid & !sb_v[EXE_LATENCY]) sched_err <= 1'b1;
      if (!empty & !system_stall & hazard & (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_exe_issue_scheduler.sv
// tb_exe_issue_scheduler: directed + random bench for exe_issue_scheduler.
// In-order architectural model predicts every issued uop's operands and final RF.
module tb_exe_issue_scheduler;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int LAT   = 2;
`ifdef EXE_SCHED_BYPASS_EN
  localparam int T3_GAP   = 2;
  localparam int T3_STALL = 1;
`else
  localparam int T3_GAP   = 3;
  localparam int T3_STALL = 2;
`endif

  typedef struct {
    logic [6:0]  t;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [20:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wr;
  } uop_t;

  logic clk, reset, system_stall, force_rv;
  logic [AW-1:0] rf_rs1_addr, rf_rs2_addr, rf_wr_addr;
  logic [DW-1:0] rf_rs1_data, rf_rs2_data, exe_src1, exe_src2;
  logic [DW-1:0] exe_result, rf_wr_data;
  logic          exe_issue, exe_result_valid, rf_wr_en, sched_err;
  logic [6:0]    exe_instr_type, exe_funct7;
  logic [2:0]    exe_funct3;
  logic [20:0]   exe_imm;
  logic [15:0]   stall_cnt;

  logic [DW-1:0] rf [32];
  logic [DW-1:0] rf_init [32];
  logic [DW-1:0] march [32];
  logic [LAT:1]  pv;
  logic [DW-1:0] pres [LAT:1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  uop_t q[$];
  int iss_cyc[$];
  logic [DW-1:0] iss_s1[$];
  int wr_cyc[$];
  logic [4:0] wr_addr[$];

  exe_issue_scheduler_if #(.REG_AW(AW)) dec_if ();

  exe_issue_scheduler #(
    .DATA_WIDTH(DW), .REG_AW(AW), .DEPTH(DEPTH), .EXE_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .dec(dec_if),
    .system_stall(system_stall),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .exe_issue(exe_issue), .exe_instr_type(exe_instr_type),
    .exe_funct3(exe_funct3), .exe_funct7(exe_funct7), .exe_imm(exe_imm),
    .exe_src1(exe_src1), .exe_src2(exe_src2),
    .exe_result(exe_result), .exe_result_valid(exe_result_valid),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .sched_err(sched_err), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // environment: register file and a LAT-deep execution pipe (src1+src2+imm)
  assign rf_rs1_data      = rf[rf_rs1_addr];
  assign rf_rs2_data      = rf[rf_rs2_addr];
  assign exe_result_valid = pv[LAT] | force_rv;
  assign exe_result       = pres[LAT];

  always @(posedge clk) begin
    if (reset) begin
      rf <= rf_init;
      pv <= '0;
    end else begin
      if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
      pv[1]   <= exe_issue;
      pres[1] <= exe_src1 + exe_src2 + {11'b0, exe_imm};
      for (int k = 2; k <= LAT; k++) begin
        pv[k]   <= pv[k-1];
        pres[k] <= pres[k-1];
      end
    end
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic offer(uop_t u);
    dec_if.dec_valid      = 1'b1;
    dec_if.dec_instr_type = u.t;
    dec_if.dec_funct3     = u.f3;
    dec_if.dec_funct7     = u.f7;
    dec_if.dec_imm        = u.imm;
    dec_if.dec_rs1        = u.rs1;
    dec_if.dec_rs2        = u.rs2;
    dec_if.dec_rd         = u.rd;
    dec_if.dec_rd_wr      = u.wr;
  endtask

  function automatic uop_t mk(logic [4:0] rd, logic [4:0] rs1,
                              logic [4:0] rs2, logic wr);
    uop_t u;
    u.t = 7'b0110011; u.f3 = 3'd0; u.f7 = 7'd0; u.imm = 21'd0;
    u.rd = rd; u.rs1 = rs1; u.rs2 = rs2; u.wr = wr;
    return u;
  endfunction

  task automatic clear_logs();
    iss_cyc.delete(); iss_s1.delete();
    wr_cyc.delete(); wr_addr.delete();
  endtask

  // one clock: check at negedge, then step past the posedge
  task automatic tick();
    uop_t e, n;
    logic [DW-1:0] s1, s2;
    @(negedge clk);
    if (reset) begin
      q.delete();
    end else begin
      check("dec_ready", 32'(dec_if.dec_ready), 32'(q.size() < DEPTH));
      if (q.size() == 0) check("idle_issue", 32'(exe_issue), 0);
      if (exe_issue && q.size() > 0) begin
        e  = q.pop_front();
        s1 = (e.rs1 == 0) ? '0 : march[e.rs1];
        s2 = (e.rs2 == 0) ? '0 : march[e.rs2];
        check("itype", 32'(exe_instr_type), 32'(e.t));
        check("funct3", 32'(exe_funct3), 32'(e.f3));
        check("funct7", 32'(exe_funct7), 32'(e.f7));
        check("imm", 32'(exe_imm), 32'(e.imm));
        check("src1", exe_src1, s1);
        check("src2", exe_src2, s2);
        if (e.wr && e.rd != 0) march[e.rd] = s1 + s2 + {11'b0, e.imm};
        iss_cyc.push_back(cyc);
        iss_s1.push_back(exe_src1);
      end else if (!exe_issue) begin
        check("zero_src", exe_src1 | exe_src2, 0);
      end
      if (rf_wr_en) begin
        wr_cyc.push_back(cyc);
        wr_addr.push_back(rf_wr_addr);
      end
      if (dec_if.dec_valid && dec_if.dec_ready) begin
        n.t = dec_if.dec_instr_type; n.f3 = dec_if.dec_funct3;
        n.f7 = dec_if.dec_funct7; n.imm = dec_if.dec_imm;
        n.rs1 = dec_if.dec_rs1; n.rs2 = dec_if.dec_rs2;
        n.rd = dec_if.dec_rd; n.wr = dec_if.dec_rd_wr;
        q.push_back(n);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(int n);
    dec_if.dec_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    uop_t u;
    for (int i = 0; i < 32; i++) rf_init[i] = $urandom;
    rf_init[0] = 32'hDEADBEEF;
    rf_init[2] = 5; rf_init[3] = 7;
    rf_init[5] = 10; rf_init[6] = 20;
    for (int i = 0; i < 32; i++) march[i] = rf_init[i];
    march[0] = '0;
    dec_if.dec_valid = 1'b0;
    u = mk(0, 0, 0, 0);
    offer(u);
    dec_if.dec_valid = 1'b0;
    system_stall = 1'b0;
    force_rv = 1'b0;

    // 1 reset
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(dec_if.dec_ready), 1);
    check("rst_issue", 32'(exe_issue), 0);
    check("rst_wr", 32'(rf_wr_en), 0);
    check("rst_err", 32'(sched_err), 0);
    check("rst_stall", 32'(stall_cnt), 0);
    @(posedge clk); cyc++; #1;

    // 2 independent adds
    clear_logs();
    offer(mk(1, 2, 3, 1)); tick();
    offer(mk(4, 5, 6, 1)); tick();
    idle(5);
    check("t2_niss", iss_cyc.size(), 2);
    check("t2_nwr", wr_cyc.size(), 2);
    if (iss_cyc.size() == 2 && wr_cyc.size() == 2) begin
      check("t2_gap", iss_cyc[1] - iss_cyc[0], 1);
      check("t2_wa0", 32'(wr_addr[0]), 1);
      check("t2_wa1", 32'(wr_addr[1]), 4);
      check("t2_lat0", wr_cyc[0] - iss_cyc[0], LAT);
      check("t2_lat1", wr_cyc[1] - iss_cyc[1], LAT);
    end
    check("t2_stall", 32'(stall_cnt), 0);

    // 3 RAW dependency x1 -> x4
    clear_logs();
    offer(mk(1, 2, 3, 1)); tick();
    offer(mk(4, 1, 1, 1)); tick();
    idle(6);
    check("t3_niss", iss_cyc.size(), 2);
    if (iss_cyc.size() == 2) begin
      check("t3_gap", iss_cyc[1] - iss_cyc[0], T3_GAP);
      check("t3_src", iss_s1[1], 12);
    end
    check("t3_stall", 32'(stall_cnt), T3_STALL);

    // 4 fill under system_stall, then release
    clear_logs();
    system_stall = 1'b1;
    offer(mk(8, 2, 3, 1)); tick();
    offer(mk(9, 5, 6, 1)); tick();
    offer(mk(10, 2, 5, 1));
    @(negedge clk);
    check("t4_full", 32'(dec_if.dec_ready), 0);
    check("t4_noiss", 32'(exe_issue), 0);
    @(posedge clk); cyc++; #1;
    system_stall = 1'b0;
    idle(6);
    check("t4_niss", iss_cyc.size(), 2);
    if (iss_cyc.size() == 2) check("t4_gap", iss_cyc[1] - iss_cyc[0], 1);

    // 5 x0 writer then x0 reader
    clear_logs();
    offer(mk(0, 2, 3, 1)); tick();
    offer(mk(7, 0, 0, 0)); tick();
    idle(6);
    check("t5_nwr", wr_cyc.size(), 0);
    check("t5_niss", iss_cyc.size(), 2);
    if (iss_cyc.size() == 2) begin
      check("t5_gap", iss_cyc[1] - iss_cyc[0], 1);
      check("t5_src", iss_s1[1], 0);
    end
    check("t5_stall", 32'(stall_cnt), T3_STALL);

    // random traffic against the in-order model
    for (int i = 0; i < 400; i++) begin
      u.t = 7'($urandom); u.f3 = 3'($urandom); u.f7 = 7'($urandom);
      u.imm = 21'($urandom_range(0, 15));
      u.rs1 = 5'($urandom_range(0, 7)); u.rs2 = 5'($urandom_range(0, 7));
      u.rd = 5'($urandom_range(0, 7)); u.wr = 1'($urandom);
      offer(u);
      dec_if.dec_valid = ($urandom_range(0, 2) != 0);
      system_stall = ($urandom_range(0, 4) == 0);
      tick();
    end
    system_stall = 1'b0;
    idle(10);
    check("rnd_drain", q.size(), 0);
    for (int r = 1; r < 8; r++) check("rnd_rf", rf[r], march[r]);

    // 6 spurious result -> sticky sched_err
    clear_logs();
    force_rv = 1'b1; tick();
    force_rv = 1'b0;
    check("t6_err", 32'(sched_err), 1);
    check("t6_nowr", wr_cyc.size(), 0);
    idle(3);
    check("t6_sticky", 32'(sched_err), 1);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check("t6_clr", 32'(sched_err), 0);
    check("t6_stclr", 32'(stall_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
